// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined immediate generator: opcodes,
// immediate-format encodings, buffer occupancy states and XLEN helpers.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;

  function automatic logic xlen_supported(input int unsigned xlen);
    return (xlen == 32'd32) || (xlen == 32'd64);
  endfunction

  function automatic logic is_rv64(input int unsigned xlen);
    return (xlen == 32'd64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: instruction word -> extended immediate,
// format, illegal flag and whether a PC-relative target is produced.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       type_o,
  output logic            illegal_o,
  output logic            pc_rel_o
);

  localparam logic RV64 = is_rv64(XLEN);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [31:0] raw_s;
  logic [31:0] i_imm_s;
  logic [31:0] s_imm_s;
  logic [31:0] b_imm_s;
  logic [31:0] u_imm_s;
  logic [31:0] j_imm_s;

  assign opcode_s = instr_i[6:0];
  assign funct3_s = instr_i[14:12];

  assign i_imm_s = {{20{instr_i[31]}}, instr_i[31:20]};
  assign s_imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign b_imm_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
  assign u_imm_s = {instr_i[31:12], 12'd0};
  assign j_imm_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

  // Format selection; zero-extended CSR fields are built with a clear bit 31
  // so the common sign extension below leaves them zero-extended.
  always_comb begin
    raw_s     = 32'd0;
    type_o    = IMM_NONE;
    illegal_o = 1'b0;
    pc_rel_o  = 1'b0;
    case (opcode_s)
      OPC_LOAD, OPC_JALR: begin
        type_o = IMM_I;
        raw_s  = i_imm_s;
      end
      OPC_OPIMM: begin
        if (!RV64 && ((funct3_s == 3'd1) || (funct3_s == 3'd5)) && instr_i[25]) begin
          illegal_o = 1'b1;
        end else begin
          type_o = IMM_I;
          raw_s  = i_imm_s;
        end
      end
      OPC_OPIMM32: begin
        if (RV64) begin
          type_o = IMM_I;
          raw_s  = i_imm_s;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_STORE: begin
        type_o = IMM_S;
        raw_s  = s_imm_s;
      end
      OPC_BRANCH: begin
        type_o   = IMM_B;
        raw_s    = b_imm_s;
        pc_rel_o = 1'b1;
      end
      OPC_LUI: begin
        type_o = IMM_U;
        raw_s  = u_imm_s;
      end
      OPC_AUIPC: begin
        type_o   = IMM_U;
        raw_s    = u_imm_s;
        pc_rel_o = 1'b1;
      end
      OPC_JAL: begin
        type_o   = IMM_J;
        raw_s    = j_imm_s;
        pc_rel_o = 1'b1;
      end
      OPC_SYSTEM: begin
        if (funct3_s[2]) begin
          type_o = IMM_Z;
          raw_s  = {27'd0, instr_i[19:15]};
        end else if (funct3_s != 3'd0) begin
          type_o = IMM_I;
          raw_s  = {20'd0, instr_i[31:20]};
        end else begin
          type_o = IMM_NONE;
        end
      end
      OPC_OP, OPC_FENCE: begin
        type_o = IMM_NONE;
      end
      OPC_OP32: begin
        if (RV64) begin
          type_o = IMM_NONE;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

  assign imm_o = XLEN'({{32{raw_s[31]}}, raw_s});

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer (main/skid) and a
// saturating illegal-instruction counter.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic [XLEN-1:0]  in_pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_instr_o,
  output logic [XLEN-1:0]  out_pc_o,
  output logic [XLEN-1:0]  out_imm_o,
  output logic [2:0]       out_type_o,
  output logic [XLEN-1:0]  out_target_o,
  output logic             out_illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  // Entry layout, LSB first: illegal, target, type, imm, pc, instr.
  localparam int unsigned TGT_LO   = 1;
  localparam int unsigned TYPE_LO  = TGT_LO + XLEN;
  localparam int unsigned IMM_LO   = TYPE_LO + 3;
  localparam int unsigned PC_LO    = IMM_LO + XLEN;
  localparam int unsigned INSTR_LO = PC_LO + XLEN;
  localparam int unsigned EW       = INSTR_LO + 32;

  logic [XLEN-1:0]  dec_imm_s;
  imm_type_e        dec_type_s;
  logic             dec_illegal_s;
  logic             dec_pc_rel_s;
  logic [XLEN-1:0]  target_s;
  logic [EW-1:0]    entry_s;
  logic             accept_s;
  logic             pop_s;

  buf_state_e       state_q, state_d;
  logic [EW-1:0]    main_q, main_d;
  logic [EW-1:0]    skid_q, skid_d;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr_i  (in_instr_i),
    .imm_o    (dec_imm_s),
    .type_o   (dec_type_s),
    .illegal_o(dec_illegal_s),
    .pc_rel_o (dec_pc_rel_s)
  );

  assign target_s = dec_pc_rel_s ? (in_pc_i + dec_imm_s) : {XLEN{1'b0}};
  assign entry_s  = {in_instr_i, in_pc_i, dec_imm_s, dec_type_s, target_s, dec_illegal_s};

  assign accept_s = in_valid_i & in_ready_q;
  assign pop_s    = out_valid_q & out_ready_i;

  // Occupancy next-state and entry movement; FULL never sees an accept
  // because in_ready is low there.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept_s) begin
          main_d  = entry_s;
          state_d = BUF_ONE;
        end else begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_ONE: begin
        if (accept_s && pop_s) begin
          main_d  = entry_s;
          state_d = BUF_ONE;
        end else if (accept_s) begin
          skid_d  = entry_s;
          state_d = BUF_FULL;
        end else if (pop_s) begin
          state_d = BUF_EMPTY;
        end else begin
          state_d = BUF_ONE;
        end
      end
      BUF_FULL: begin
        if (pop_s) begin
          main_d  = skid_q;
          state_d = BUF_ONE;
        end else begin
          state_d = BUF_FULL;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
  end

  // Saturating illegal count; holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_s && dec_illegal_s && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, buffer and handshake registers; flags are derived from the
  // next state so in_ready and out_valid stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BUF_EMPTY;
      main_q      <= {EW{1'b0}};
      skid_q      <= {EW{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != BUF_EMPTY);
      in_ready_q  <= (state_d != BUF_FULL);
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_illegal_o = main_q[0];
  assign out_target_o  = main_q[TYPE_LO-1:TGT_LO];
  assign out_type_o    = main_q[IMM_LO-1:TYPE_LO];
  assign out_imm_o     = main_q[PC_LO-1:IMM_LO];
  assign out_pc_o      = main_q[INSTR_LO-1:PC_LO];
  assign out_instr_o   = main_q[EW-1:INSTR_LO];
  assign illegal_cnt_o = cnt_q;

endmodule
